// File: rtl/bus_force_seq.sv
// Stimulus sequencer for the tri-state bus checker: steps LOAD -> FORCE -> RELEASE -> DONE
// and publishes the driver value, the per-bit force overlay and the resolved bus.
module bus_force_seq #(
  parameter int               WIDTH    = 4,
  parameter int               HOLD_CYC = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = 4'b0101,
  parameter logic [WIDTH-1:0] FRC_MASK = 4'b0011,
  parameter logic [WIDTH-1:0] FRC_VAL  = 4'b0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] frc_en,
  output logic [WIDTH-1:0] frc_val,
  output logic [WIDTH-1:0] bus_res,
  output logic [2:0]       state,
  output logic [7:0]       step,
  output logic             busy,
  output logic             done
);

  localparam int H  = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] HCNT_LAST = CW'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FORCE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_bus_in;
  logic [WIDTH-1:0] r_frc_en;
  logic [WIDTH-1:0] r_frc_val;
  logic [CW-1:0]    r_hcnt;
  logic [7:0]       r_step;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_bus_nxt;
  logic [WIDTH-1:0] w_fen_nxt;
  logic [WIDTH-1:0] w_fval_nxt;
  logic [CW-1:0]    w_hcnt_nxt;
  logic [7:0]       w_step_nxt;
  logic             w_done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bus_in  <= '0;
      r_frc_en  <= '0;
      r_frc_val <= '0;
      r_hcnt    <= '0;
      r_step    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_in  <= w_bus_nxt;
      r_frc_en  <= w_fen_nxt;
      r_frc_val <= w_fval_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_step    <= w_step_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bus_nxt   = r_bus_in;
    w_fen_nxt   = r_frc_en;
    w_fval_nxt  = r_frc_val;
    w_hcnt_nxt  = r_hcnt;
    w_step_nxt  = r_step;
    w_done_nxt  = 1'b0;

    if (r_state != S_IDLE && r_step != 8'hFF) w_step_nxt = r_step + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_LOAD;
          w_bus_nxt   = INIT_VAL;
          w_step_nxt  = '0;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_FORCE;
        w_fen_nxt   = FRC_MASK;
        w_fval_nxt  = FRC_VAL & FRC_MASK;
        w_hcnt_nxt  = '0;
      end
      S_FORCE: begin
        if (r_hcnt == HCNT_LAST) begin
          w_state_nxt = S_RELEASE;
          w_fen_nxt   = '0;
          w_hcnt_nxt  = '0;
        end else begin
          w_hcnt_nxt  = r_hcnt + CW'(1);
        end
      end
      S_RELEASE: begin
        if (r_hcnt == HCNT_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_hcnt_nxt  = r_hcnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fen_nxt   = '0;
      end
    endcase

    // Abort from any active state drops the force; DONE exits to IDLE regardless.
    if (abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_fen_nxt   = '0;
    end

    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign bus_in  = r_bus_in;
  assign frc_en  = r_frc_en;
  assign frc_val = r_frc_val;
  assign bus_res = (r_bus_in & ~r_frc_en) | (r_frc_val & r_frc_en);
  assign state   = r_state;
  assign step    = r_step;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_bus_force_seq.sv
// Bench for bus_force_seq: three hold settings (2, 0, 200) driven in lockstep and
// compared every cycle against a schedule model keyed on edges elapsed since start.
module tb_bus_force_seq;

  localparam logic [3:0] INIT = 4'b0101;
  localparam logic [3:0] MASK = 4'b0011;
  localparam logic [3:0] FVAL = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [2:0][3:0] bus_in_o, frc_en_o, frc_val_o, bus_res_o;
  logic [2:0][2:0] state_o;
  logic [2:0][7:0] step_o;
  logic [2:0]      busy_o, done_o;

  always #5 clk = ~clk;

  bus_force_seq #(.WIDTH(4), .HOLD_CYC(2), .INIT_VAL(INIT), .FRC_MASK(MASK), .FRC_VAL(FVAL)) u_h2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bus_in(bus_in_o[0]), .frc_en(frc_en_o[0]), .frc_val(frc_val_o[0]), .bus_res(bus_res_o[0]),
    .state(state_o[0]), .step(step_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  bus_force_seq #(.WIDTH(4), .HOLD_CYC(0), .INIT_VAL(INIT), .FRC_MASK(MASK), .FRC_VAL(FVAL)) u_h0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bus_in(bus_in_o[1]), .frc_en(frc_en_o[1]), .frc_val(frc_val_o[1]), .bus_res(bus_res_o[1]),
    .state(state_o[1]), .step(step_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  bus_force_seq #(.WIDTH(4), .HOLD_CYC(200), .INIT_VAL(INIT), .FRC_MASK(MASK), .FRC_VAL(FVAL)) u_h200 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bus_in(bus_in_o[2]), .frc_en(frc_en_o[2]), .frc_val(frc_val_o[2]), .bus_res(bus_res_o[2]),
    .state(state_o[2]), .step(step_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  int tests = 0;
  int fails = 0;

  // Effective hold length per instance (0 behaves as 1).
  int         hh[3] = '{2, 1, 200};
  bit         m_act[3];
  int         m_t[3];
  int         m_step[3];
  logic [3:0] m_bus[3];
  logic [3:0] m_fv[3];

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, i, obs, exp);
    end
  endtask

  // Phase t after start edge: 0 LOAD, 1..H FORCE, H+1..2H RELEASE, 2H+1 DONE.
  function automatic logic [2:0] exp_state(input int i);
    if (!m_act[i])               return 3'd0;
    if (m_t[i] == 0)             return 3'd1;
    if (m_t[i] <= hh[i])         return 3'd2;
    if (m_t[i] <= 2 * hh[i])     return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [3:0] exp_fen(input int i);
    return (m_act[i] && m_t[i] >= 1 && m_t[i] <= hh[i]) ? MASK : 4'b0000;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 1'b0; m_bus[i] = '0; m_fv[i] = '0; m_step[i] = 0;
      end else if (!m_act[i]) begin
        if (start && !abort) begin
          m_act[i] = 1'b1; m_t[i] = 0; m_bus[i] = INIT; m_step[i] = 0;
        end
      end else begin
        if (m_step[i] < 255) m_step[i]++;
        if (abort) m_act[i] = 1'b0;
        else begin
          m_t[i]++;
          if (m_t[i] == 1) m_fv[i] = FVAL & MASK;
          if (m_t[i] == 2 * hh[i] + 2) m_act[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] fen;
    for (int i = 0; i < 3; i++) begin
      fen = exp_fen(i);
      chk("state",   i, 8'(state_o[i]),   8'(exp_state(i)));
      chk("bus_in",  i, 8'(bus_in_o[i]),  8'(m_bus[i]));
      chk("frc_en",  i, 8'(frc_en_o[i]),  8'(fen));
      chk("frc_val", i, 8'(frc_val_o[i]), 8'(m_fv[i]));
      chk("bus_res", i, 8'(bus_res_o[i]), 8'((m_bus[i] & ~fen) | (m_fv[i] & fen)));
      chk("step",    i, step_o[i],        8'(m_step[i]));
      chk("busy",    i, 8'(busy_o[i]),    8'(m_act[i]));
      chk("done",    i, 8'(done_o[i]),    8'(exp_state(i) == 3'd4));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; tick();
    rst = 1'b0; tick();

    // Nominal sequence, start at edge 0
    start = 1'b1; tick();
    chk("tp_res_e0", 0, 8'(bus_res_o[0]), 8'h05);
    start = 1'b0; tick();
    chk("tp_res_e1", 0, 8'(bus_res_o[0]), 8'h06);
    chk("tp_fen_e1", 0, 8'(frc_en_o[0]), 8'h03);
    run(2);
    chk("tp_res_e3", 0, 8'(bus_res_o[0]), 8'h05);
    chk("tp_fen_e3", 0, 8'(frc_en_o[0]), 8'h00);
    run(2);
    chk("tp_done_e5", 0, 8'(done_o[0]), 8'h01);
    chk("tp_step_e5", 0, step_o[0], 8'd5);
    tick();
    chk("tp_state_e6", 0, 8'(state_o[0]), 8'h00);
    chk("tp_busy_e6", 0, 8'(busy_o[0]), 8'h00);
    run(2);

    // Reset while in FORCE, then a clean rerun
    start = 1'b1; tick();
    start = 1'b0; tick();
    rst = 1'b1; tick();
    chk("rst_bus_res", 0, 8'(bus_res_o[0]), 8'h00);
    rst = 1'b0;
    start = 1'b1; tick();
    start = 1'b0; run(7);

    // Abort during RELEASE
    start = 1'b1; tick();
    start = 1'b0; run(3);
    abort = 1'b1; tick();
    abort = 1'b0;
    chk("abort_state", 0, 8'(state_o[0]), 8'h00);
    chk("abort_bus_in", 0, 8'(bus_in_o[0]), 8'h05);
    run(4);

    // Start while busy is ignored
    start = 1'b1; tick();
    start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0; run(5);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1; tick();
    chk("start_abort_idle", 0, 8'(state_o[0]), 8'h00);
    start = 1'b0; abort = 1'b0; tick();

    // Long hold: step saturates on the HOLD_CYC=200 instance
    start = 1'b1; tick();
    start = 1'b0; run(410);
    chk("step_sat", 2, step_o[2], 8'd255);

    // Randomized start/abort/reset traffic
    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom % 64) == 0;
      start = ($urandom % 4) == 0;
      abort = ($urandom % 16) == 0;
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
